lut_pipe_arbiter: RTL and testbench
===================================

# lut_pipe_arbiter

Round-robin arbiter and sequencer that shares one registered 6-input AND pipeline (input register, second register stage, AND LUT, result register, output register) among `NUM_REQ` requesters. It accepts at most one operand set per cycle, carries a requester tag and valid bit through every stage, and returns each result with its tag. A single downstream `res_ready` backpressures the pipeline. It sits between several CLB-benchmark stimulus sources and the shared reg-LUT-reg datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 6: operand width, i.e. the AND fan-in, 2..6.
- `ID_W`, default 2: tag width, must equal ceil(log2(`NUM_REQ`)), minimum 1.

- `clock0`  in  1  single clock. All logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  bit i: requester i presents operands.
- `req_data`  in  NUM_REQ*WIDTH  requester i operands at bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NUM_REQ  bit i: requester i accepted this cycle. One-hot or zero.
- `res_valid`  out  1  result present.
- `res_data`  out  1  AND of all WIDTH bits of the accepted operand.
- `res_id`  out  ID_W  index of the originating requester.
- `res_ready`  in  1  downstream accepts the result.
- `busy`  out  1  any pipeline stage holds a valid entry.

## Operation
- Pipeline has 4 stages, each with a valid bit, a tag and data:
  - S1: `in_reg`, WIDTH bits.
  - S2: `reg1`, WIDTH bits.
  - S3: `out_reg2`, 1 bit. Loads the AND-reduction of S2.
  - S4: the output register, which drives `res_valid`, `res_data` and `res_id`.
- `stall = res_valid & ~res_ready`.
  - While stall is high, every stage holds its contents and `req_ready` is all-zero.
  - Otherwise every stage shifts one step.
- Bubbles are not compressed. An invalid stage shifts like a valid one.
- Arbitration is combinational round-robin:
  - A pointer `ptr` (0..NUM_REQ-1) marks the highest-priority requester.
  - The grant goes to the first i, searching ptr, ptr+1, … (mod NUM_REQ), with `req_valid[i]`=1.
  - `req_ready[i] = grant[i] & ~stall`.
- Acceptance happens when `req_valid[i] & req_ready[i]`.
  - On acceptance, S1 loads the data of requester i, tag = i, valid = 1.
  - On the same edge, `ptr` is set to (i+1) mod NUM_REQ.
- No acceptance and no stall: S1 loads valid = 0, and `ptr` is unchanged.
- `req_ready` depends combinationally on `req_valid`. A requester must hold valid and data stable until it is accepted.
- Fairness: a continuously valid requester is accepted within NUM_REQ accepts.
- `busy` = OR of the S1..S4 valid bits.
- Reset:
  - All valid bits, data, tags and `ptr` clear to 0.
  - `res_valid`=0, `res_data`=0, `res_id`=0, `busy`=0, `req_ready` all 0 during reset.
- Reset in mid-operation discards all in-flight entries. No result is emitted for them.

## Timing
- Latency: an operand accepted at edge T gives `res_valid`=1 after edge T+3, i.e. visible in cycle T+3 (4 register stages counting S1). Each stall cycle adds one cycle.
- Throughput: 1 accept per cycle with no stall. A steady stream from all requesters gives an accept every cycle.
- A result is consumed at the edge where `res_valid & res_ready`. The pipeline advances on that same edge.
- Simultaneous events:
  - If a stall clears in a cycle, acceptance is allowed in that same cycle.
  - If `res_ready` drops while `res_valid`=1, the stall takes effect the same cycle (`req_ready` goes 0 combinationally).
- Wrap: after accepting requester NUM_REQ-1, `ptr` returns to 0.

## Test plan
- Single request: requester 2, data 6'b111111, `res_ready`=1.
  - `req_ready[2]` is high 1 cycle.
  - 3 cycles later: `res_valid`=1, `res_data`=1, `res_id`=2, `busy` high for 4 cycles.
  - Repeat with 6'b111101: `res_data`=0.
- Round-robin: all 4 requesters valid continuously, with `res_ready`=1.
  - Accept order is 0,1,2,3,0,1.
  - `res_id` sequence is 0,1,2,3,0,1, with one result per cycle.
- Skip: after `ptr`=1, only requesters 0 and 3 are valid.
  - Accepts 3, then 0, then 3.
- Backpressure: stream from requester 1, then hold `res_ready`=0 for 5 cycles once `res_valid`=1.
  - `req_ready` is 0 and all outputs are frozen for 5 cycles.
  - When released, results resume in order with no loss or duplication.
- Reset mid-flight: accept 3 operands, assert `reset` for 1 cycle.
  - All outputs are 0 and `busy`=0 after the reset edge. No stale `res_valid` appears afterward.
  - A new request from requester 0 is granted first (`ptr`=0).

Source files
------------

// File: rtl/lut_pipe_arbiter.sv
// Round-robin arbiter feeding a shared 4-stage registered AND-LUT pipeline.
// Each stage carries a valid bit and a requester tag, and a single downstream ready stalls every stage.
module lut_pipe_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 6,
    parameter int ID_W    = 2
) (
    input  logic                     clock0,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    output logic                     res_data,
    output logic [ID_W-1:0]          res_id,
    input  logic                     res_ready,
    output logic                     busy
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]    ptr_r;

    logic               s1_valid_r;
    logic [ID_W-1:0]    s1_id_r;
    logic [WIDTH-1:0]   s1_data_r;
    logic               s2_valid_r;
    logic [ID_W-1:0]    s2_id_r;
    logic [WIDTH-1:0]   s2_data_r;
    logic               s3_valid_r;
    logic [ID_W-1:0]    s3_id_r;
    logic               s3_data_r;
    logic               s4_valid_r;
    logic [ID_W-1:0]    s4_id_r;
    logic               s4_data_r;

    logic               stall_s;
    logic               found_s;
    logic               accept_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [ID_W-1:0]    grant_id_s;
    logic [WIDTH-1:0]   grant_data_s;

    // A held result blocks every stage and the requester side in the same cycle.
    assign stall_s = s4_valid_r & ~res_ready;

    // Round-robin search starting at ptr_r, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] cand_v;
        grant_s    = '0;
        grant_id_s = '0;
        found_s    = 1'b0;
        cand_v     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_v = {1'b0, ptr_r} + (ID_W+1)'(k);
            if (cand_v >= NUM_REQ_W) begin
                cand_v = cand_v - NUM_REQ_W;
            end else begin
                cand_v = cand_v;
            end
            if (!found_s && req_valid[cand_v[ID_W-1:0]]) begin
                grant_s[cand_v[ID_W-1:0]] = 1'b1;
                grant_id_s                = cand_v[ID_W-1:0];
                found_s                   = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Operand mux driven by the one-hot grant; zero when nothing is granted.
    always_comb begin
        grant_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                grant_data_s = req_data[i*WIDTH +: WIDTH];
            end else begin
                grant_data_s = grant_data_s;
            end
        end
    end

    assign accept_s  = found_s & ~stall_s & ~reset;
    assign req_ready = grant_s & {NUM_REQ{~stall_s & ~reset}};

    // Pipeline shift, priority pointer update and synchronous clear.
    always_ff @(posedge clock0) begin
        if (reset) begin
            ptr_r      <= '0;
            s1_valid_r <= 1'b0;
            s1_id_r    <= '0;
            s1_data_r  <= '0;
            s2_valid_r <= 1'b0;
            s2_id_r    <= '0;
            s2_data_r  <= '0;
            s3_valid_r <= 1'b0;
            s3_id_r    <= '0;
            s3_data_r  <= 1'b0;
            s4_valid_r <= 1'b0;
            s4_id_r    <= '0;
            s4_data_r  <= 1'b0;
        end else if (!stall_s) begin
            // Bubbles shift like valid entries; S1 takes a bubble when nobody is granted.
            s1_valid_r <= accept_s;
            s1_id_r    <= grant_id_s;
            s1_data_r  <= grant_data_s;
            s2_valid_r <= s1_valid_r;
            s2_id_r    <= s1_id_r;
            s2_data_r  <= s1_data_r;
            s3_valid_r <= s2_valid_r;
            s3_id_r    <= s2_id_r;
            s3_data_r  <= &s2_data_r;
            s4_valid_r <= s3_valid_r;
            s4_id_r    <= s3_id_r;
            s4_data_r  <= s3_data_r;
            if (accept_s) begin
                if (grant_id_s == LAST_ID) begin
                    ptr_r <= '0;
                end else begin
                    ptr_r <= grant_id_s + ID_W'(1);
                end
            end else begin
                ptr_r <= ptr_r;
            end
        end else begin
            ptr_r      <= ptr_r;
            s1_valid_r <= s1_valid_r;
            s1_id_r    <= s1_id_r;
            s1_data_r  <= s1_data_r;
            s2_valid_r <= s2_valid_r;
            s2_id_r    <= s2_id_r;
            s2_data_r  <= s2_data_r;
            s3_valid_r <= s3_valid_r;
            s3_id_r    <= s3_id_r;
            s3_data_r  <= s3_data_r;
            s4_valid_r <= s4_valid_r;
            s4_id_r    <= s4_id_r;
            s4_data_r  <= s4_data_r;
        end
    end

    assign res_valid = s4_valid_r;
    assign res_data  = s4_data_r;
    assign res_id    = s4_id_r;
    assign busy      = s1_valid_r | s2_valid_r | s3_valid_r | s4_valid_r;

endmodule

// File: tb/tb_lut_pipe_arbiter.sv
// Directed self-checking bench for lut_pipe_arbiter: latency, round-robin order, skip,
// backpressure freeze/resume and mid-flight reset.
module tb_lut_pipe_arbiter;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 6;
    localparam int ID_W    = 2;

    logic                     clock0 = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     res_valid;
    logic                     res_data;
    logic [ID_W-1:0]          res_id;
    logic                     res_ready;
    logic                     busy;

    int checks = 0;
    int errors = 0;

    lut_pipe_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clock0    (clock0),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clock0 = ~clock0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock0);
        #1;
    endtask

    task automatic set_data(input int idx, input logic [WIDTH-1:0] v);
        req_data[idx*WIDTH +: WIDTH] = v;
    endtask

    // Requester 2 alone; result must appear three edges after acceptance.
    task automatic single_req(input logic [WIDTH-1:0] d, input logic exp_and);
        set_data(2, d);
        req_valid = 4'b0100;
        #1;
        check("single_ready", req_ready, 4'b0100);
        tick;
        req_valid = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            check("single_busy", busy, (c < 4));
            check("single_valid", res_valid, (c == 3));
            if (c == 3) begin
                check("single_data", res_data, exp_and);
                check("single_id", res_id, 2);
            end
            tick;
        end
    endtask

    logic [3:0] rr_and;
    logic [3:0] exp_rdy;
    logic [3:0] skip_exp [4];
    logic [7:0] bp_r;
    int         next_k;
    logic       stall_exp;
    int         j;

    initial begin
        reset     = 1'b1;
        req_valid = 4'b0000;
        req_data  = '0;
        res_ready = 1'b1;
        tick;
        tick;
        // Reset state, including req_ready held low while requests are present.
        req_valid = 4'b1111;
        #1;
        check("rst_ready", req_ready, 4'b0000);
        check("rst_valid", res_valid, 1'b0);
        check("rst_data", res_data, 1'b0);
        check("rst_id", res_id, 2'd0);
        check("rst_busy", busy, 1'b0);
        req_valid = 4'b0000;
        reset     = 1'b0;
        tick;

        single_req(6'b111111, 1'b1);
        single_req(6'b111101, 1'b0);

        reset = 1'b1;
        tick;
        reset = 1'b0;

        // Round-robin with all four requesters valid.
        set_data(0, 6'h3F);
        set_data(1, 6'h00);
        set_data(2, 6'h3F);
        set_data(3, 6'h1F);
        rr_and = 4'b0101;
        for (int c = 0; c < 9; c++) begin
            if (c >= 6) req_valid = 4'b0000;
            else        req_valid = 4'b1111;
            #1;
            if (c < 6) begin
                exp_rdy = 4'b0001 << (c % 4);
                check("rr_ready", req_ready, exp_rdy);
            end
            tick;
            check("rr_valid", res_valid, (c >= 3));
            if (c >= 3) begin
                check("rr_id", res_id, (c - 3) % 4);
                check("rr_data", res_data, rr_and[(c - 3) % 4]);
            end
        end
        tick;
        tick;

        // Skip: move ptr to 1 via requester 0, then only 0 and 3 compete.
        skip_exp[0] = 4'b0001;
        skip_exp[1] = 4'b1000;
        skip_exp[2] = 4'b0001;
        skip_exp[3] = 4'b1000;
        for (int s = 0; s < 4; s++) begin
            req_valid = (s == 0) ? 4'b0001 : 4'b1001;
            #1;
            check("skip_ready", req_ready, skip_exp[s]);
            tick;
        end
        req_valid = 4'b0000;
        for (int s = 0; s < 5; s++) tick;
        check("skip_drain_busy", busy, 1'b0);

        // Backpressure: stream from requester 1, stall for edges 4..8.
        bp_r   = 8'b0100_1101;
        next_k = 0;
        for (int e = 0; e < 17; e++) begin
            res_ready = !(e >= 4 && e <= 8);
            stall_exp = !res_ready;
            if (next_k < 8) begin
                req_valid = 4'b0010;
                set_data(1, bp_r[next_k] ? 6'h3F : 6'h2A);
            end else begin
                req_valid = 4'b0000;
            end
            #1;
            exp_rdy = (stall_exp || next_k >= 8) ? 4'b0000 : 4'b0010;
            check("bp_ready", req_ready, exp_rdy);
            tick;
            if (!stall_exp && next_k < 8) next_k++;
            if (e < 3) begin
                check("bp_fill_valid", res_valid, 1'b0);
            end else if (e <= 8) begin
                check("bp_hold_valid", res_valid, 1'b1);
                check("bp_hold_id", res_id, 2'd1);
                check("bp_hold_data", res_data, bp_r[0]);
                check("bp_hold_busy", busy, 1'b1);
            end else begin
                j = e - 8;
                check("bp_resume_valid", res_valid, (j <= 7));
                if (j <= 7) begin
                    check("bp_resume_id", res_id, 2'd1);
                    check("bp_resume_data", res_data, bp_r[j]);
                end
            end
        end
        res_ready = 1'b1;
        check("bp_accept_count", next_k, 8);

        // Mid-flight reset: ptr is 2 here, so grants go 2,3,0.
        skip_exp[0] = 4'b0100;
        skip_exp[1] = 4'b1000;
        skip_exp[2] = 4'b0001;
        req_valid   = 4'b1111;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("mid_ready", req_ready, skip_exp[s]);
            tick;
        end
        req_valid = 4'b0000;
        check("mid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check("mid_rst_valid", res_valid, 1'b0);
        check("mid_rst_data", res_data, 1'b0);
        check("mid_rst_id", res_id, 2'd0);
        check("mid_rst_busy", busy, 1'b0);
        for (int s = 0; s < 4; s++) begin
            tick;
            check("mid_no_stale", res_valid, 1'b0);
        end
        req_valid = 4'b1111;
        #1;
        check("mid_ptr0_ready", req_ready, 4'b0001);
        tick;
        req_valid = 4'b0000;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
